alu_issue_ctrl: RTL and testbench

//   Issue/writeback stage directly upstream of the 4-bit registered ALU.
//   - Accepts instructions over a valid/ready handshake.
//   - Reads operands from a small internal register file and drives the ALU inputs.
//   - Captures the ALU's registered result and flags one cycle later, writes the result back.
//   - Keeps a sticky overflow flag and a retired-instruction counter.

---
 rtl/alu_issue_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue/writeback controller sitting in front of a 4-bit registered ALU.
// An instruction is accepted over a valid/ready handshake. Its operands are
// read from a 4-entry register file and presented to the ALU for one cycle.
// The ALU's registered result is written back one cycle later. The block
// also keeps the zero flag of the last retired instruction, a sticky
// overflow flag and a wrapping retired-instruction counter.
//
// Instruction word (in_instr):
//   [9]   imm_sel  0: src_a = reg[rs1], src_b = reg[rs2]
//                  1: src_a = reg[rd],  src_b = in_instr[3:0]
//   [8:6] opcode   passed through to the ALU; every opcode writes back
//   [5:4] rd
//   [3:2] rs1
//   [1:0] rs2
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   in_valid/in_ready instruction handshake (ready only in IDLE)
//   in_instr          instruction word, see above
//   alu_src_a/b       ALU operands, zero outside EXEC
//   alu_opcode        ALU opcode, 000 outside EXEC
//   alu_out           ALU registered result (valid during WB)
//   alu_overflow      ALU registered overflow (valid during WB)
//   alu_zero          ALU registered zero (valid during WB)
//   clr_flags         clears ovf_sticky; a same-edge overflow wins
//   dbg_addr/dbg_data combinational register file read port
//   busy              controller not in IDLE
//   zero_flag         alu_zero of the last retired instruction
//   ovf_sticky        OR of alu_overflow since reset or last clear
//   retire            one-cycle pulse in the IDLE cycle after each WB
//   retired_cnt       retired instruction count, wraps to 0
//
// State table:
//   state | meaning
//   IDLE  | ready for a new instruction, ALU inputs parked at zero
//   EXEC  | operands and opcode driven to the ALU
//   WB    | ALU result valid; written back at the end of this cycle
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int NREGS = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [9:0]       in_instr,
    output logic             in_ready,
    output logic [3:0]       alu_src_a,
    output logic [3:0]       alu_src_b,
    output logic [2:0]       alu_opcode,
    input  logic [3:0]       alu_out,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    input  logic             clr_flags,
    input  logic [1:0]       dbg_addr,
    output logic [3:0]       dbg_data,
    output logic             busy,
    output logic             zero_flag,
    output logic             ovf_sticky,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [9:0] instr_q;
    logic [3:0] regs_q [NREGS];

    logic       accept;
    logic       wb_fire;
    logic       imm_sel;
    logic [2:0] op_q;
    logic [1:0] rd_q;
    logic [1:0] rs1_q;
    logic [1:0] rs2_q;
    logic [3:0] imm_q;

    assign imm_sel = instr_q[9];
    assign op_q    = instr_q[8:6];
    assign rd_q    = instr_q[5:4];
    assign rs1_q   = instr_q[3:2];
    assign rs2_q   = instr_q[1:0];
    assign imm_q   = instr_q[3:0];

    assign accept  = in_valid && in_ready;
    assign wb_fire = (state_q == WB);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        in_ready   = 1'b0;
        busy       = 1'b1;
        alu_opcode = 3'b000;
        alu_src_a  = 4'd0;
        alu_src_b  = 4'd0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            EXEC: begin
                alu_opcode = op_q;
                if (imm_sel) begin
                    alu_src_a = regs_q[rd_q];
                    alu_src_b = imm_q;
                end else begin
                    alu_src_a = regs_q[rs1_q];
                    alu_src_b = regs_q[rs2_q];
                end
            end
            default: ;
        endcase
    end

    // Instruction latch; only loaded on a handshake so the word stays
    // stable through EXEC and WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
        end else if (accept) begin
            instr_q <= in_instr;
        end
    end

    // Register file. The write lands at the WB->IDLE edge, so a debug read
    // during WB still shows the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 4'd0;
            end
        end else if (wb_fire) begin
            regs_q[rd_q] <= alu_out;
        end
    end

    assign dbg_data = regs_q[dbg_addr];

    // Flags, retire pulse and counter. Reset takes priority, which also
    // drops any instruction still in EXEC or WB without writing it back.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_flag   <= 1'b1;
            ovf_sticky  <= 1'b0;
            retire      <= 1'b0;
            retired_cnt <= '0;
        end else begin
            retire <= wb_fire;
            if (wb_fire) begin
                zero_flag   <= alu_zero;
                retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // A new overflow beats a simultaneous clear.
            if (wb_fire && alu_overflow) begin
                ovf_sticky <= 1'b1;
            end else if (clr_flags) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [9:0] in_instr;
    logic       in_ready;
    logic [3:0] alu_src_a;
    logic [3:0] alu_src_b;
    logic [2:0] alu_opcode;
    logic [3:0] alu_out;
    logic       alu_overflow;
    logic       alu_zero;
    logic       clr_flags;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;
    logic       busy;
    logic       zero_flag;
    logic       ovf_sticky;
    logic       retire;
    logic [7:0] retired_cnt;

    int total = 0;
    int bad   = 0;

    alu_issue_ctrl #(.NREGS(4), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_opcode   (alu_opcode),
        .alu_out      (alu_out),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .clr_flags    (clr_flags),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .busy         (busy),
        .zero_flag    (zero_flag),
        .ovf_sticky   (ovf_sticky),
        .retire       (retire),
        .retired_cnt  (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the downstream registered ALU.
    // 000 clr, 001 and, 010 or, 011 xor, 100 add, 101 sub, 110 shl1, 111 not a
    always @(posedge clk) begin
        logic [3:0] r;
        logic       v;
        r = 4'd0;
        v = 1'b0;
        case (alu_opcode)
            3'b000: r = 4'd0;
            3'b001: r = alu_src_a & alu_src_b;
            3'b010: r = alu_src_a | alu_src_b;
            3'b011: r = alu_src_a ^ alu_src_b;
            3'b100: begin
                r = alu_src_a + alu_src_b;
                v = (alu_src_a[3] == alu_src_b[3]) && (r[3] != alu_src_a[3]);
            end
            3'b101: begin
                r = alu_src_a - alu_src_b;
                v = (alu_src_a[3] != alu_src_b[3]) && (r[3] != alu_src_a[3]);
            end
            3'b110: r = {alu_src_a[2:0], 1'b0};
            default: r = ~alu_src_a;
        endcase
        alu_out      <= r;
        alu_overflow <= v;
        alu_zero     <= (r == 4'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0] instr;
        logic       clr;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic [3:0] exp_res;
        logic       exp_zero;
        logic       exp_ovf;
    } vec_t;

    vec_t       vecs [12];
    logic [3:0] shadow [4];
    logic [7:0] exp_cnt;

    // Runs one instruction from IDLE through retire, checking each phase.
    task automatic run_instr(input vec_t v, input string tag);
        logic [1:0] rd;
        int         n;
        rd = v.instr[5:4];
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_instr = v.instr;
        dbg_addr = rd;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, " exec busy"}, busy, 1'b1);
        chk({tag, " exec in_ready"}, in_ready, 1'b0);
        chk({tag, " exec opcode"}, alu_opcode, v.instr[8:6]);
        chk({tag, " exec src_a"}, alu_src_a, v.exp_a);
        chk({tag, " exec src_b"}, alu_src_b, v.exp_b);
        chk({tag, " exec retire"}, retire, 1'b0);
        @(posedge clk);
        #1;
        clr_flags = v.clr;
        @(negedge clk);
        chk({tag, " wb opcode"}, alu_opcode, 3'b000);
        chk({tag, " wb src"}, {alu_src_a, alu_src_b}, 8'h00);
        chk({tag, " wb old dbg"}, dbg_data, shadow[rd]);
        @(posedge clk);
        #1;
        clr_flags = 1'b0;
        shadow[rd] = v.exp_res;
        exp_cnt = exp_cnt + 8'd1;
        @(negedge clk);
        chk({tag, " retire"}, retire, 1'b1);
        chk({tag, " result"}, dbg_data, v.exp_res);
        chk({tag, " zero_flag"}, zero_flag, v.exp_zero);
        chk({tag, " ovf_sticky"}, ovf_sticky, v.exp_ovf);
        chk({tag, " retired_cnt"}, retired_cnt, exp_cnt);
        chk({tag, " idle ready"}, in_ready, 1'b1);
    endtask

    initial begin
        int         acc_cyc [2];
        int         acc_n;
        vec_t       v;

        //          instr                       clr   a      b      res    z     ovf
        vecs[0]  = '{10'b1_100_01_0101,        1'b0, 4'h0, 4'h5, 4'h5, 1'b0, 1'b0};
        vecs[1]  = '{10'b1_100_01_0100,        1'b1, 4'h5, 4'h4, 4'h9, 1'b0, 1'b1};
        vecs[2]  = '{10'b1_100_10_1001,        1'b0, 4'h0, 4'h9, 4'h9, 1'b0, 1'b1};
        vecs[3]  = '{10'b0_101_11_01_10,       1'b0, 4'h9, 4'h9, 4'h0, 1'b1, 1'b1};
        vecs[4]  = '{10'b1_011_00_0000,        1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[5]  = '{10'b1_001_01_0011,        1'b0, 4'h9, 4'h3, 4'h1, 1'b0, 1'b0};
        vecs[6]  = '{10'b0_010_00_01_11,       1'b0, 4'h1, 4'h0, 4'h1, 1'b0, 1'b0};
        vecs[7]  = '{10'b1_110_10_0000,        1'b0, 4'h9, 4'h0, 4'h2, 1'b0, 1'b0};
        vecs[8]  = '{10'b1_111_11_0000,        1'b0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0};
        vecs[9]  = '{10'b1_000_10_0111,        1'b0, 4'h2, 4'h7, 4'h0, 1'b1, 1'b0};
        vecs[10] = '{10'b1_101_00_0010,        1'b0, 4'h1, 4'h2, 4'hF, 1'b0, 1'b0};
        vecs[11] = '{10'b1_101_01_1000,        1'b0, 4'h1, 4'h8, 4'h9, 1'b0, 1'b1};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        clr_flags = 1'b0;
        dbg_addr  = 2'd0;
        for (int i = 0; i < 4; i++) shadow[i] = 4'h0;
        exp_cnt = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst in_ready", in_ready, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst zero_flag", zero_flag, 1'b1);
        chk("rst ovf_sticky", ovf_sticky, 1'b0);
        chk("rst retire", retire, 1'b0);
        chk("rst retired_cnt", retired_cnt, 8'd0);
        chk("rst alu idle", {alu_opcode, alu_src_a, alu_src_b}, 11'd0);
        for (int a = 0; a < 4; a++) begin
            dbg_addr = a[1:0];
            #1;
            chk("rst dbg_data", dbg_data, 4'h0);
        end

        for (int i = 0; i < 12; i++) begin
            run_instr(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: valid held 6 cycles with two queued instructions
        @(posedge clk);
        #1;
        dbg_addr = 2'd0;
        in_valid = 1'b1;
        in_instr = 10'b1_100_00_0001;
        acc_n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (acc_n < 2) acc_cyc[acc_n] = c;
                acc_n++;
            end
            @(posedge clk);
            #1;
            if (acc_n == 1) in_instr = 10'b1_100_00_0010;
        end
        in_valid = 1'b0;
        shadow[0] = shadow[0] + 4'd3;
        exp_cnt   = exp_cnt + 8'd2;
        @(negedge clk);
        chk("bp accept count", acc_n, 2);
        if (acc_n >= 2) chk("bp accept spacing", acc_cyc[1] - acc_cyc[0], 3);
        chk("bp reg0", dbg_data, shadow[0]);
        chk("bp retire", retire, 1'b1);
        chk("bp retired_cnt", retired_cnt, exp_cnt);
        chk("bp ovf_sticky", ovf_sticky, 1'b1);

        // Reset while the instruction is in EXEC
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_instr = 10'b1_100_00_0011;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) shadow[i] = 4'h0;
        exp_cnt = 8'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rexec retire", retire, 1'b0);
            chk("rexec reg0", dbg_data, 4'h0);
            chk("rexec retired_cnt", retired_cnt, 8'd0);
            chk("rexec busy", busy, 1'b0);
        end
        chk("rexec ovf_sticky", ovf_sticky, 1'b0);
        chk("rexec zero_flag", zero_flag, 1'b1);

        // Counter wrap: 255 back-to-back clears, then one more through the checker
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_instr = 10'b1_000_00_0000;
        repeat (765) @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_cnt  = 8'd255;
        @(negedge clk);
        chk("wrap cnt 255", retired_cnt, 8'd255);
        v = '{10'b1_000_00_0000, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
        run_instr(v, "wrap");
        chk("wrap cnt 0", retired_cnt, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
